// File: rtl/hack_mmio_if.sv
// CPU-side data-memory bus for the Hack MMIO block: write strobe, read
// strobe, word address, write data and combinational read data.
interface hack_mmio_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
) ();
  logic              load;
  logic              rd;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  in;
  logic [WIDTH-1:0]  out;

  modport master (output load, rd, address, in, input out);
  modport slave  (input load, rd, address, in, output out);
endinterface

// File: rtl/hack_mmio_memory.sv
// Hack data memory with decoded RAM, screen and an I/O page holding a
// buffered keyboard FIFO (pop-on-read, overflow flag) and a loadable timer.
module hack_mmio_memory #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 15,
  parameter int SCREEN_LOG2 = ADDR_W - 2,
  parameter int FIFO_LOG2   = 2
) (
  input  logic             clk,
  input  logic             reset,
  hack_mmio_if.slave       bus,
  input  logic [WIDTH-1:0] kbd_code,
  input  logic             kbd_strobe,
  output logic             kbd_irq
);
  localparam int OFF_W = ADDR_W - 1;
  localparam int D     = 1 << FIFO_LOG2;
  localparam int CW    = FIFO_LOG2 + 1;
  localparam logic [OFF_W-1:0] SCR_WORDS = OFF_W'(1 << SCREEN_LOG2);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(D);

  logic [WIDTH-1:0] ram    [1 << OFF_W];
  logic [WIDTH-1:0] screen [1 << SCREEN_LOG2];
  logic [WIDTH-1:0] fifo   [D];

  logic [FIFO_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]        count, count_nx;
  logic                 ovf;
  logic [WIDTH-1:0]     timer;

  logic             upper, is_ram, is_scr, is_io;
  logic             is_peek, is_pop, is_stat, is_timer;
  logic [OFF_W-1:0] off, io_off;
  logic [WIDTH-1:0] head;
  logic             empty, full, pop, push, ovf_set, stat_wr;

  assign upper    = bus.address[ADDR_W-1];
  assign off      = bus.address[OFF_W-1:0];
  assign is_ram   = !upper;
  assign is_scr   = upper && (off < SCR_WORDS);
  assign is_io    = upper && !is_scr;
  assign io_off   = off - SCR_WORDS;
  assign is_peek  = is_io && (io_off == OFF_W'(0));
  assign is_pop   = is_io && (io_off == OFF_W'(1));
  assign is_stat  = is_io && (io_off == OFF_W'(2));
  assign is_timer = is_io && (io_off == OFF_W'(3));

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = empty ? '0 : fifo[rptr];
  // rd qualifies the pop so address-only CPU cycles never consume a key.
  assign pop     = bus.rd && is_pop && !empty;
  assign push    = kbd_strobe && (!full || pop);
  assign ovf_set = kbd_strobe && full && !pop;
  assign stat_wr = bus.load && is_stat;

  always_comb begin
    count_nx = count;
    if (push && !pop)      count_nx = count + CW'(1);
    else if (!push && pop) count_nx = count - CW'(1);
  end

  always_comb begin
    bus.out = '0;
    if (is_ram)                 bus.out = ram[off];
    else if (is_scr)            bus.out = screen[off[SCREEN_LOG2-1:0]];
    else if (is_peek || is_pop) bus.out = head;
    else if (is_stat) begin
      bus.out[WIDTH-1] = ovf;
      bus.out[CW-1:0]  = count;
    end
    else if (is_timer)          bus.out = timer;
  end

  // Storage arrays carry no reset; reset only blocks writes in its cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (bus.load && is_ram) ram[off] <= bus.in;
      if (bus.load && is_scr) screen[off[SCREEN_LOG2-1:0]] <= bus.in;
      if (push)               fifo[wptr] <= kbd_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      timer   <= '0;
      kbd_irq <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count   <= count_nx;
      kbd_irq <= (count_nx != '0);
      // A dropped key in the same cycle as a clearing write keeps the flag.
      if (ovf_set)      ovf <= 1'b1;
      else if (stat_wr) ovf <= 1'b0;
      if (bus.load && is_timer) timer <= bus.in;
      else                      timer <= timer + 1'b1;
    end
  end
endmodule

// File: tb/tb_hack_mmio_memory.sv
// Directed bench: stimulus queues expected read data / irq per cycle and a
// negedge monitor drains and compares the scoreboard.
module tb_hack_mmio_memory;
  localparam logic [14:0] PEEK  = 15'h6000;
  localparam logic [14:0] POP   = 15'h6001;
  localparam logic [14:0] STAT  = 15'h6002;
  localparam logic [14:0] TIMER = 15'h6003;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic        kbd_irq;

  hack_mmio_if #(.WIDTH(16), .ADDR_W(15)) bus ();

  hack_mmio_memory #(.WIDTH(16), .ADDR_W(15), .SCREEN_LOG2(13), .FIFO_LOG2(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .kbd_code(kbd_code), .kbd_strobe(kbd_strobe), .kbd_irq(kbd_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
    bit          irq;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge clk) begin
    while (sb.size() != 0) begin
      exp_t        e;
      logic [15:0] act;
      e   = sb.pop_front();
      act = e.irq ? {15'b0, kbd_irq} : bus.out;
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic drive(input logic ld, input logic r, input logic [14:0] a,
                       input logic [15:0] d, input logic stb, input logic [15:0] code);
    bus.load = ld; bus.rd = r; bus.address = a; bus.in = d;
    kbd_strobe = stb; kbd_code = code;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.load = 1'b0; bus.rd = 1'b0; kbd_strobe = 1'b0;
  endtask

  task automatic exp_out(input string n, input logic [15:0] v);
    sb.push_back('{name: n, exp: v, irq: 1'b0});
  endtask

  task automatic exp_irq(input string n, input logic v);
    sb.push_back('{name: n, exp: {15'b0, v}, irq: 1'b1});
  endtask

  task automatic push_key(input logic [15:0] code);
    drive(1'b0, 1'b0, PEEK, 16'h0, 1'b1, code); tick();
  endtask

  task automatic rd_chk(input string n, input logic [14:0] a, input logic r, input logic [15:0] v);
    drive(1'b0, r, a, 16'h0, 1'b0, 16'h0); exp_out(n, v); tick();
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    drive(1'b1, 1'b0, a, d, 1'b0, 16'h0); tick();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 16'h0);
    tick(); tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, STAT, 16'h0, 1'b0, 16'h0);
    exp_out("init_stat", 16'h0000); exp_irq("init_irq", 1'b0); tick();

    // Overflow: 5 pushes into depth 4, then clear by write
    for (int i = 0; i < 5; i++) push_key(16'h0010 + 16'(i));
    rd_chk("ovf_stat", STAT, 1'b0, 16'h8004);
    rd_chk("ovf_head", PEEK, 1'b0, 16'h0010);
    wr(STAT, 16'h0000);
    rd_chk("ovf_clr", STAT, 1'b0, 16'h0004);

    // Build state for the reset test: overflow set, two entries left
    push_key(16'h0015);
    rd_chk("pre_pop0", POP, 1'b1, 16'h0010);
    rd_chk("pre_pop1", POP, 1'b1, 16'h0011);
    drive(1'b0, 1'b0, STAT, 16'h0, 1'b0, 16'h0);
    exp_out("pre_stat", 16'h8002); exp_irq("pre_irq", 1'b1); tick();

    // Reset with a timer write and a strobe in the same cycle
    reset = 1'b0;
    drive(1'b1, 1'b0, TIMER, 16'h5555, 1'b1, 16'h0099);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, TIMER, 16'h0, 1'b0, 16'h0);
    exp_out("rst_timer0", 16'h0000); exp_irq("rst_irq", 1'b0); tick();
    rd_chk("rst_timer1", TIMER, 1'b0, 16'h0001);
    rd_chk("rst_stat", STAT, 1'b0, 16'h0000);
    rd_chk("rst_peek", PEEK, 1'b0, 16'h0000);

    // FIFO order and irq fall
    push_key(16'h0041); push_key(16'h0042); push_key(16'h0043);
    rd_chk("pop_nord", POP, 1'b0, 16'h0041);
    rd_chk("peek_kept", PEEK, 1'b0, 16'h0041);
    drive(1'b0, 1'b1, POP, 16'h0, 1'b0, 16'h0);
    exp_out("pop1", 16'h0041); exp_irq("irq_p1", 1'b1); tick();
    rd_chk("pop2", POP, 1'b1, 16'h0042);
    drive(1'b0, 1'b1, POP, 16'h0, 1'b0, 16'h0);
    exp_out("pop3", 16'h0043); exp_irq("irq_p3", 1'b1); tick();
    drive(1'b0, 1'b1, POP, 16'h0, 1'b0, 16'h0);
    exp_out("pop_empty", 16'h0000); exp_irq("irq_fall", 1'b0); tick();
    rd_chk("empty_stat", STAT, 1'b0, 16'h0000);

    // Full FIFO: ignored writes, set-wins, push+pop when full
    for (int i = 1; i <= 4; i++) push_key(16'(i));
    wr(PEEK, 16'hAAAA);
    wr(POP, 16'hBBBB);
    rd_chk("wr_peek_head", PEEK, 1'b0, 16'h0001);
    rd_chk("wr_peek_stat", STAT, 1'b0, 16'h0004);
    drive(1'b1, 1'b0, STAT, 16'h0, 1'b1, 16'h0009); tick();
    rd_chk("setwins_stat", STAT, 1'b0, 16'h8004);
    wr(STAT, 16'hFFFF);
    rd_chk("clr2_stat", STAT, 1'b0, 16'h0004);
    drive(1'b0, 1'b1, POP, 16'h0, 1'b1, 16'h0005);
    exp_out("fullpp_pop", 16'h0001); tick();
    rd_chk("fullpp_stat", STAT, 1'b0, 16'h0004);
    for (int i = 2; i <= 5; i++) rd_chk("fullpp_seq", POP, 1'b1, 16'(i));
    rd_chk("fullpp_end", STAT, 1'b0, 16'h0000);

    // Timer load and wrap
    wr(TIMER, 16'hFFFE);
    rd_chk("tmr_load", TIMER, 1'b0, 16'hFFFE);
    rd_chk("tmr_ffff", TIMER, 1'b0, 16'hFFFF);
    rd_chk("tmr_wrap", TIMER, 1'b0, 16'h0000);
    rd_chk("tmr_next", TIMER, 1'b0, 16'h0001);

    // Map decode
    wr(15'h0005, 16'h1234);
    wr(15'h4005, 16'hBEEF);
    wr(15'h3FFF, 16'hCAFE);
    wr(15'h5FFF, 16'h0F0F);
    wr(15'h6004, 16'h7777);
    wr(15'h7FFF, 16'h7777);
    rd_chk("ram_5", 15'h0005, 1'b0, 16'h1234);
    rd_chk("scr_5", 15'h4005, 1'b0, 16'hBEEF);
    rd_chk("ram_top", 15'h3FFF, 1'b0, 16'hCAFE);
    rd_chk("scr_top", 15'h5FFF, 1'b0, 16'h0F0F);
    rd_chk("io_4", 15'h6004, 1'b0, 16'h0000);
    rd_chk("io_last", 15'h7FFF, 1'b0, 16'h0000);
    rd_chk("peek_after", PEEK, 1'b0, 16'h0000);

    @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
